// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses imem, queues {instr, pc} for decode.
// Latency: instruction at PC X is visible to decode one cycle after imem_addr = X; redirect to target in 2 cycles.
// Backpressure: id_valid/id_ready handshake; PC stalls when the queue is full and nothing pops.
//
// Ports:
//   clk, rst                     rising-edge clock, asynchronous active-high reset
//   imem_addr / imem_rd          combinational instruction memory read (address = PC)
//   redirect / redirect_target   execute-stage branch/jump; flushes the queue and reloads the PC
//   id_valid / id_ready          head-of-queue handshake to decode
//   id_instr, id_pc, id_pc_plus4 head entry (NOP / 0 / 0 when id_valid = 0)
// Optional (macro FETCH_PERF_CNT_EN): perf_fetched, perf_flushed saturating event counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    localparam logic [31:0] NOP = 32'h00000013;

    // Pointer width never drops to zero so DEPTH = 1 still has a legal index.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 1 << PTR_W;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0] ent_instr_q [SLOTS];
    logic [31:0] ent_instr_d [SLOTS];
    logic [31:0] ent_pc_q    [SLOTS];
    logic [31:0] ent_pc_d    [SLOTS];

    logic pop;
    logic push;

    assign imem_addr   = pc_q;
    assign id_valid    = (count_q != '0);
    assign id_instr    = id_valid ? ent_instr_q[rd_ptr_q] : NOP;
    assign id_pc       = id_valid ? ent_pc_q[rd_ptr_q] : 32'h0;
    assign id_pc_plus4 = id_valid ? (ent_pc_q[rd_ptr_q] + 32'd4) : 32'h0;

    assign pop  = id_valid & id_ready;
    // A full queue can still accept a word when the head leaves in the same cycle.
    assign push = ~redirect & ((count_q < FULL_CNT) | pop);

    always_comb begin
        pc_d        = pc_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        ent_instr_d = ent_instr_q;
        ent_pc_d    = ent_pc_q;

        if (redirect) begin
            // Flush by collapsing the read pointer onto the write pointer;
            // the target is forced word-aligned.
            pc_d     = redirect_target & ~32'h3;
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) begin
                ent_instr_d[wr_ptr_q] = imem_rd;
                ent_pc_d[wr_ptr_q]    = pc_q;
                wr_ptr_d              = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
                pc_d                  = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Payload storage needs no reset: visibility is gated by count.
    always_ff @(posedge clk) begin
        ent_instr_q <= ent_instr_d;
        ent_pc_q    <= ent_pc_d;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0]      perf_fetched_q, perf_fetched_d;
    logic [31:0]      perf_flushed_q, perf_flushed_d;
    logic [CNT_W-1:0] flush_amt;
    logic [32:0]      flushed_sum;

    // Entries discarded unconsumed: a head popped in the redirect cycle is not lost.
    assign flush_amt   = count_q - CNT_W'(pop);
    assign flushed_sum = {1'b0, perf_flushed_q} + 33'(flush_amt);

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_flushed_d = perf_flushed_q;
        if (push && perf_fetched_q != 32'hFFFFFFFF) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (redirect) begin
            perf_flushed_d = flushed_sum[32] ? 32'hFFFFFFFF : flushed_sum[31:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule
